instr_encoder: RTL

- Inverse of the RV32I instruction decoder. Takes instruction fields (format, opcode, funct3/funct7, register addresses, 32-bit immediate) and packs them into a standards-conformant 32-bit RV32I word.
- Checks that the immediate is in range for the selected format.
- Buffers results in a 2-entry valid/ready queue.
- Used by the self-test stimulus generator and boot-sequence builder that feed the fetch/decode path.

---
 rtl/instr_encoder_pkg.sv | 38 +++
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder_enc_fifo2.sv | 61 ++++++
 rtl/instr_encoder.sv | 108 ++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// RV32I encoder shared types: instruction formats, base opcodes, immediate limits.
// Pure declarations; no timing or backpressure.
package r2rv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Branch and jump targets are byte offsets, so their upper limits are even.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output of the encoder, valid/ready on both sides.
// The master drives bundles and consumes words; the slave is the encoder.
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

endinterface

// File: rtl/instr_encoder_enc_fifo2.sv
// Two-entry valid/ready queue, head held in a register: 1 cycle push-to-output latency.
// push_rdy_o depends only on occupancy, so no ready path runs through from the pop side.
module enc_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld_i,
  output logic         push_rdy_o,
  input  logic [W-1:0] push_dat_i,
  output logic         pop_vld_o,
  input  logic         pop_rdy_i,
  output logic [W-1:0] pop_dat_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign push_rdy_o = (count_q != 2'd2);
  assign pop_vld_o  = (count_q != 2'd0);
  assign pop_dat_o  = head_q;
  assign push       = push_vld_i && push_rdy_o;
  assign pop        = pop_vld_o && pop_rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Push and pop together only happens at count 1 (empty cannot pop, full cannot push).
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_dat_i;
        else                 tail_d = push_dat_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        head_d = push_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I fields into a 32-bit word with an immediate range check; 1 cycle latency.
// Output queued in a 2-entry buffer; in_ready drops only when both entries are full.
module instr_encoder
  import r2rv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  fmt_t        fmt;
  logic [31:0] imm;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic [32:0] head_dat;
  logic        pop;

  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign fmt = fmt_t'(bus.in_fmt);
  assign imm = bus.in_imm;

  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     bus.in_rd, bus.in_opcode};
      end
      FMT_I: begin
        enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        enc_err   = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     imm[4:0], bus.in_opcode};
        enc_err   = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     imm[4:1], imm[11], bus.in_opcode};
        enc_err   = !imm_in_range(imm, IMMB_MIN, IMMB_MAX) || imm[0];
      end
      FMT_U: begin
        enc_instr = {imm[31:12], bus.in_rd, bus.in_opcode};
        enc_err   = |imm[11:0];
      end
      FMT_J: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        enc_err   = !imm_in_range(imm, IMMJ_MIN, IMMJ_MAX) || imm[0];
      end
      // Encodings 6 and 7 are not formats: emit an all-zero word flagged as bad.
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  enc_fifo2 #(
    .W(33)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (bus.in_valid),
    .push_rdy_o (bus.in_ready),
    .push_dat_i ({enc_err, enc_instr}),
    .pop_vld_o  (bus.out_valid),
    .pop_rdy_i  (bus.out_ready),
    .pop_dat_o  (head_dat)
  );

  assign bus.out_err   = head_dat[32];
  assign bus.out_instr = head_dat[31:0];
  assign pop           = bus.out_valid && bus.out_ready;

  // enc_count wraps; err_count sticks at all-ones so a long run never hides errors.
  always_comb begin
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (pop) begin
      enc_count_d = enc_count_q + CNT_W'(1);
      if (bus.out_err && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule
